// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage access sequencer for the 32-bit ARM pipeline.
// Each load or store becomes a fixed-latency transaction of WAIT_STATES
// ACCESS cycles. While a transaction is in flight, the pipeline is frozen
// through ready. Load data is latched into data_mem for the MEM/WB register.
// Optional feature macro: MEM_BOUNDS_CHECK_EN enables address range and
// alignment checking and the addr_err pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; a request latches address/data/op
// ACCESS | wait states counting down; the last cycle writes or captures
// DONE   | result valid, ready high, EX/MEM advances on the next edge
module mem_access_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 3,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MEM_R_EN,
   input  logic          MEM_W_EN,
   input  logic [31:0]   alu_res,
   input  logic [31:0]   rm_val,
   output logic          ready,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_we,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   data_mem,
   output logic          addr_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        load_q;
   logic        req;
   logic        latch_en;
   logic        last_access;
   logic        capture;
   logic        bad_addr;

   assign req = MEM_R_EN | MEM_W_EN;

   // The array sees only latched values, so they stay stable for the whole transaction.
   assign mem_addr  = AW'((addr_q - BASE_ADDR) >> 2);
   assign mem_wdata = wdata_q;

`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic [32:0] ADDR_LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);

   // Address check on the latched address: below the base, past the array end, or misaligned.
   always_comb begin
      bad_addr = 1'b0;
      if ((addr_q < BASE_ADDR) || ({1'b0, addr_q} >= ADDR_LIMIT) || (addr_q[1:0] != 2'b00))
         bad_addr = 1'b1;
   end

   assign addr_err = (state_q == ST_DONE) && bad_addr;
`else
   // Without checking, out-of-range offsets wrap and misaligned addresses truncate.
   assign bad_addr = 1'b0;
   assign addr_err = 1'b0;
`endif

   // State, wait counter, request latch and load-result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         load_q   <= 1'b0;
         data_mem <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_en) begin
            addr_q  <= alu_res;
            wdata_q <= rm_val;
            load_q  <= MEM_R_EN;
         end
         if (capture)
            data_mem <= bad_addr ? 32'd0 : mem_rdata;
      end
   end

   // Next-state logic, counter update and strobes. mem_we is decoded from the state, so reset drops it at once.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      latch_en    = 1'b0;
      last_access = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               last_access = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready   = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
      mem_we  = last_access && !load_q && !bad_addr;
      capture = last_access && load_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with default parameters.
// The default parameters are BASE 1024, DEPTH 64 and 3 wait states.
// The bench contains a behavioural data array driven by mem_addr/mem_we.
module tb_mem_access_ctrl;

   localparam int W = 3;
`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] alu_res;
   logic [31:0] rm_val;
   logic        ready;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] data_mem;
   logic        addr_err;

   logic [31:0] tb_mem [64];
   int checks = 0;
   int errors = 0;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .MEM_R_EN  (MEM_R_EN),
      .MEM_W_EN  (MEM_W_EN),
      .alu_res   (alu_res),
      .rm_val    (rm_val),
      .ready     (ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .data_mem  (data_mem),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   // Data array: combinational read, write on the rising edge.
   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we)
         tb_mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // The request starts just after a rising edge, so that cycle is cycle 0. The task returns mid-DONE with the request still held.
   task automatic txn(input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_we, input logic [5:0] exp_addr,
                      input logic exp_err, input logic [31:0] exp_data);
      @(posedge clk);
      #1;
      MEM_R_EN = rd;
      MEM_W_EN = wr;
      alu_res  = addr;
      rm_val   = wdata;
      for (int k = 0; k <= W; k++) begin
         @(negedge clk);
         check($sformatf("%s_ready_c%0d", tag, k), 32'(ready), 32'd0);
         check($sformatf("%s_we_c%0d", tag, k), 32'(mem_we), 32'(exp_we && (k == W)));
         if (k == W) begin
            check($sformatf("%s_addr", tag), {26'd0, mem_addr}, {26'd0, exp_addr});
            check($sformatf("%s_err_access", tag), 32'(addr_err), 32'd0);
            if (exp_we)
               check($sformatf("%s_wdata", tag), mem_wdata, wdata);
         end
      end
      @(negedge clk);
      check($sformatf("%s_ready_done", tag), 32'(ready), 32'd1);
      check($sformatf("%s_we_done", tag), 32'(mem_we), 32'd0);
      check($sformatf("%s_err_done", tag), 32'(addr_err), 32'(exp_err));
      check($sformatf("%s_data", tag), data_mem, exp_data);
   endtask

   task automatic idle_step(input string tag);
      @(posedge clk);
      #1;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      @(negedge clk);
      check($sformatf("%s_ready_idle", tag), 32'(ready), 32'd1);
   endtask

   initial begin
      logic [31:0] d_oob;
      rst      = 1'b0;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      alu_res  = 32'd0;
      rm_val   = 32'd0;
      for (int i = 0; i < 64; i++)
         tb_mem[i] <= 32'h1000_0000 + 32'(i);
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_err", 32'(addr_err), 32'd0);
      check("rst_data", data_mem, 32'd0);
      check("rst_addr", {26'd0, mem_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b1;

      // Store then load at the base address.
      txn("st1024", 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b1, 6'd0, 1'b0, 32'd0);
      check("st1024_mem", tb_mem[0], 32'hDEAD_BEEF);
      txn("ld1024", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 6'd0, 1'b0, 32'hDEAD_BEEF);

      // Back-to-back: store, then two loads, with no bubble between them.
      txn("st1028", 1'b0, 1'b1, 32'd1028, 32'h0000_0011, 1'b1, 6'd1, 1'b0, 32'hDEAD_BEEF);
      check("st1028_mem", tb_mem[1], 32'h0000_0011);
      txn("ld1028", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 6'd1, 1'b0, 32'h0000_0011);
      txn("ld1024b", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 6'd0, 1'b0, 32'hDEAD_BEEF);
      idle_step("idle1");

      // Both enables high: behaves as a load and does not write.
      txn("both1032", 1'b1, 1'b1, 32'd1032, 32'hFFFF_FFFF, 1'b0, 6'd2, 1'b0, 32'h1000_0002);
      check("both1032_mem", tb_mem[2], 32'h1000_0002);

      // Out-of-range and misaligned addresses wrap or truncate, or are flagged when checking is on.
      d_oob = BC ? 32'd0 : 32'hDEAD_BEEF;
      txn("ld1280", 1'b1, 1'b0, 32'd1280, 32'd0, 1'b0, 6'd0, BC, d_oob);
      txn("ld1026", 1'b1, 1'b0, 32'd1026, 32'd0, 1'b0, 6'd0, BC, d_oob);
      txn("st1020", 1'b0, 1'b1, 32'd1020, 32'hCAFE_F00D, !BC, 6'd63, BC, d_oob);
      check("st1020_mem", tb_mem[63], BC ? 32'h1000_003F : 32'hCAFE_F00D);
      idle_step("idle2");

      // Reset asserted in the second ACCESS cycle of a store to word 3.
      @(posedge clk);
      #1;
      MEM_W_EN = 1'b1;
      alu_res  = 32'd1036;
      rm_val   = 32'h1234_5678;
      @(negedge clk);
      check("rstmid_ready_c0", 32'(ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_we", 32'(mem_we), 32'd0);
      MEM_W_EN = 1'b0;
      #1;
      check("rstmid_ready", 32'(ready), 32'd1);
      check("rstmid_data", data_mem, 32'd0);
      check("rstmid_err", 32'(addr_err), 32'd0);
      repeat (3) @(negedge clk);
      check("rstmid_mem", tb_mem[3], 32'h1000_0003);
      rst = 1'b1;
      txn("ld1036", 1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 6'd3, 1'b0, 32'h1000_0003);
      idle_step("idle3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
